// File: rtl/cu_decrypt.sv
// Registered decode stage: maps the IDU instruction index and side fields onto the
// 32-bit control word, plus a sticky illegal-index flag held until reset.
module cu_decrypt (
    input  logic        soc_clk,
    input  logic        reset,
    input  logic        IDU_ready,
    input  logic [5:0]  Instruction_to_CU,
    input  logic [4:0]  Instruction_to_ALU,
    input  logic [4:0]  rd,
    input  logic [1:0]  pipeline_override,
    output logic [31:0] CU_out,
    output logic        CU_decode_error
);

    // valid, decode_error, halt, jump, branch, mem_write, mem_read, reg_we
    localparam logic [31:0] ACTION_MASK = 32'h0E0C_6400;

    logic [5:0]  idx;
    logic        is_r, is_ialu, is_load, is_store, is_branch;
    logic        is_jal, is_jalr, is_lui, is_auipc, is_halt, is_illegal;
    logic        reg_we, opb_imm, opa_pc, mem_unsigned, use_shamt;
    logic [1:0]  mem_size;
    logic [31:0] next_word;

    always_comb begin
        idx        = Instruction_to_CU;
        is_r       = (idx <= 6'd9);
        is_ialu    = (idx >= 6'd10) && (idx <= 6'd18);
        is_load    = (idx >= 6'd19) && (idx <= 6'd23);
        is_store   = (idx >= 6'd24) && (idx <= 6'd26);
        is_branch  = (idx >= 6'd27) && (idx <= 6'd32);
        is_jal     = (idx == 6'd33);
        is_jalr    = (idx == 6'd34);
        is_lui     = (idx == 6'd35);
        is_auipc   = (idx == 6'd36);
        is_halt    = (idx == 6'd38) || (idx == 6'd39);
        is_illegal = (idx >= 6'd40);

        reg_we = (is_r || is_ialu || is_load || is_jal || is_jalr || is_lui || is_auipc)
                 && (rd != 5'd0);
        opb_imm      = is_ialu || is_load || is_store || is_jalr || is_lui || is_auipc;
        opa_pc       = is_auipc || is_jal;
        mem_unsigned = (idx == 6'd22) || (idx == 6'd23);
        use_shamt    = (idx >= 6'd16) && (idx <= 6'd18);

        mem_size = 2'b00;
        case (idx)
            6'd20, 6'd23, 6'd25: mem_size = 2'b01;
            6'd21, 6'd26:        mem_size = 2'b10;
            default:             mem_size = 2'b00;
        endcase

        next_word = {4'b0000, 1'b1, is_illegal, is_halt, pipeline_override,
                     use_shamt, is_lui, is_jalr, is_jal || is_jalr, is_branch,
                     mem_unsigned, mem_size, is_store, is_load, opa_pc, opb_imm,
                     reg_we, rd, Instruction_to_ALU};
    end

    always_ff @(posedge soc_clk or negedge reset) begin
        if (!reset) begin
            CU_out          <= '0;
            CU_decode_error <= 1'b0;
        end else if (IDU_ready) begin
            CU_out <= next_word;
            if (is_illegal)
                CU_decode_error <= 1'b1;
        end else begin
            // Idle cycle: drop the one-shot action bits, keep the static fields.
            CU_out <= CU_out & ~ACTION_MASK;
        end
    end

endmodule

// File: tb/tb_cu_decrypt.sv
// Directed-vector bench for cu_decrypt; expected control words are hand-computed
// from the field layout of the control word.
module tb_cu_decrypt;

    logic        soc_clk;
    logic        reset;
    logic        IDU_ready;
    logic [5:0]  Instruction_to_CU;
    logic [4:0]  Instruction_to_ALU;
    logic [4:0]  rd;
    logic [1:0]  pipeline_override;
    logic [31:0] CU_out;
    logic        CU_decode_error;

    int unsigned n_vec;
    int unsigned n_err;

    cu_decrypt dut (
        .soc_clk            (soc_clk),
        .reset              (reset),
        .IDU_ready          (IDU_ready),
        .Instruction_to_CU  (Instruction_to_CU),
        .Instruction_to_ALU (Instruction_to_ALU),
        .rd                 (rd),
        .pipeline_override  (pipeline_override),
        .CU_out             (CU_out),
        .CU_decode_error    (CU_decode_error)
    );

    initial soc_clk = 1'b0;
    always #5 soc_clk = ~soc_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 32'h%08h expected 32'h%08h", tag, got, exp);
        end
    endtask

    // Present one instruction for the next rising edge; called at a falling edge.
    task automatic issue(input logic [5:0] idx, input logic [4:0] alu,
                         input logic [4:0] dst, input logic [1:0] ovr);
        IDU_ready          = 1'b1;
        Instruction_to_CU  = idx;
        Instruction_to_ALU = alu;
        rd                 = dst;
        pipeline_override  = ovr;
        @(negedge soc_clk);
    endtask

    task automatic idle;
        IDU_ready = 1'b0;
        @(negedge soc_clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        IDU_ready = 1'b0;
        Instruction_to_CU = '0;
        Instruction_to_ALU = '0;
        rd = '0;
        pipeline_override = '0;

        repeat (3) @(negedge soc_clk);
        check("rst_word", CU_out, 32'h0);
        check("rst_err", {31'b0, CU_decode_error}, 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge soc_clk);
        check("idle_word", CU_out, 32'h0);
        check("idle_err", {31'b0, CU_decode_error}, 32'h0);

        issue(6'd0, 5'd0, 5'd3, 2'b00);
        check("add", CU_out, 32'h0800_0460);
        idle();
        check("add_hold", CU_out, 32'h0000_0060);

        issue(6'd21, 5'd0, 5'd5, 2'b00);
        check("lw", CU_out, 32'h0801_2CA0);

        issue(6'd26, 5'd0, 5'd7, 2'b10);
        check("sw", CU_out, 32'h0901_48E0);
        issue(6'd10, 5'd0, 5'd0, 2'b00);
        check("addi_x0", CU_out, 32'h0800_0800);
        idle();
        check("addi_hold", CU_out, 32'h0000_0800);

        issue(6'd39, 5'd0, 5'd0, 2'b00);
        check("ebreak", CU_out, 32'h0A00_0000);
        check("ebreak_err", {31'b0, CU_decode_error}, 32'h0);
        idle();
        check("ebreak_hold", CU_out, 32'h0);

        issue(6'd18, 5'd13, 5'd9, 2'b11);
        check("srai", CU_out, 32'h09C0_0D2D);
        issue(6'd34, 5'd0, 5'd1, 2'b00);
        check("jalr", CU_out, 32'h0818_0C20);
        issue(6'd22, 5'd0, 5'd2, 2'b00);
        check("lbu", CU_out, 32'h0802_2C40);
        issue(6'd30, 5'd3, 5'd0, 2'b00);
        check("bge", CU_out, 32'h0804_0003);
        issue(6'd36, 5'd0, 5'd4, 2'b00);
        check("auipc", CU_out, 32'h0800_1C80);
        issue(6'd37, 5'd0, 5'd0, 2'b00);
        check("fence", CU_out, 32'h0800_0000);
        check("legal_err", {31'b0, CU_decode_error}, 32'h0);

        issue(6'd45, 5'd0, 5'd6, 2'b00);
        check("ill_bit", {31'b0, CU_out[26]}, 32'h1);
        check("ill_actions", CU_out & 32'h020C_6400, 32'h0);
        check("ill_err", {31'b0, CU_decode_error}, 32'h1);
        issue(6'd0, 5'd0, 5'd3, 2'b00);
        check("add_after_ill", CU_out, 32'h0800_0460);
        check("err_sticky", {31'b0, CU_decode_error}, 32'h1);
        idle();
        check("err_sticky_idle", {31'b0, CU_decode_error}, 32'h1);

        #1 reset = 1'b0;
        #1;
        check("async_rst_err", {31'b0, CU_decode_error}, 32'h0);
        check("async_rst_word", CU_out, 32'h0);
        @(negedge soc_clk);
        reset = 1'b1;
        idle();
        check("post_rst_idle", CU_out, 32'h0);
        issue(6'd0, 5'd0, 5'd3, 2'b00);
        check("post_rst_add", CU_out, 32'h0800_0460);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
